// File: rtl/min_sec_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared types, constants and two-digit BCD helper functions
//               for the minutes:seconds timer.
// Revision    : 1.0  initial release
// ============================================================================
package timer_pkg;

  localparam int BCD_W   = 4;
  localparam int SEC_MOD = 60;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // Result of one BCD step: the new two-digit value plus the carry/borrow flag.
  typedef struct packed {
    logic       flag;
    bcd_digit_t tens;
    bcd_digit_t units;
  } bcd2_step_t;

  // Encode a decimal value 0..99 as two BCD digits.
  function automatic logic [7:0] bcd2_from_int(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Increment modulo 'mod'; flag is set when the value rolls over to 00.
  function automatic bcd2_step_t bcd2_inc(input logic [7:0] val, input int unsigned mod);
    bcd2_step_t r;
    logic [7:0] top;
    top     = bcd2_from_int(mod - 1);
    r.flag  = 1'b0;
    r.tens  = val[7:4];
    r.units = val[3:0];
    if (val == top) begin
      r.tens  = '0;
      r.units = '0;
      r.flag  = 1'b1;
    end else if (val[3:0] >= 4'd9) begin
      r.tens  = val[7:4] + 4'd1;
      r.units = '0;
    end else begin
      r.units = val[3:0] + 4'd1;
    end
    return r;
  endfunction

  // Decrement modulo 'mod'; flag is set when the value underflows 00 -> top.
  function automatic bcd2_step_t bcd2_dec(input logic [7:0] val, input int unsigned mod);
    bcd2_step_t r;
    logic [7:0] top;
    top     = bcd2_from_int(mod - 1);
    r.flag  = 1'b0;
    r.tens  = val[7:4];
    r.units = val[3:0];
    if (val == 8'h00) begin
      r.tens  = top[7:4];
      r.units = top[3:0];
      r.flag  = 1'b1;
    end else if (val[3:0] == 4'd0) begin
      r.tens  = val[7:4] - 4'd1;
      r.units = 4'd9;
    end else begin
      r.units = val[3:0] - 4'd1;
    end
    return r;
  endfunction

  // Force each digit into 0..9, then saturate the whole value at max_dec.
  function automatic logic [7:0] bcd2_clamp(input logic [7:0] val, input int unsigned max_dec);
    bcd_digit_t t;
    bcd_digit_t u;
    t = (val[7:4] > 4'd9) ? 4'd9 : val[7:4];
    u = (val[3:0] > 4'd9) ? 4'd9 : val[3:0];
    if ((32'(t) * 10 + 32'(u)) > max_dec) begin
      return bcd2_from_int(max_dec);
    end
    return {t, u};
  endfunction

endpackage
`default_nettype wire

// File: rtl/min_sec_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : min_sec_timer_if
// Description : Control/status bundle of the minutes:seconds timer.
// Revision    : 1.0  initial release
// ============================================================================
interface min_sec_timer_if;

  logic       run;
  logic       clear;
  logic       dir;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       tick;
  logic       wrap;
  logic       done;

  modport master (
    output run, clear, dir, load, load_min, load_sec,
    input  min_bcd, sec_bcd, tick, wrap, done
  );

  modport slave (
    input  run, clear, dir, load, load_min, load_sec,
    output min_bcd, sec_bcd, tick, wrap, done
  );

endinterface
`default_nettype wire

// File: rtl/bcd2_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd2_mod_counter
// Description : Two-digit BCD up/down counter modulo MOD with load and clear.
//               carry/borrow are combinational so a following digit pair can
//               step on the same edge.
// Revision    : 1.0  initial release
// ============================================================================
module bcd2_mod_counter
  import timer_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       clr,
  output logic [7:0] q,
  output logic       carry,
  output logic       borrow
);

  bcd2_step_t inc_s;
  bcd2_step_t dec_s;

  // Candidate next values in both directions.
  always_comb begin
    inc_s = bcd2_inc(q, MOD);
    dec_s = bcd2_dec(q, MOD);
  end

  assign carry  = en & ~dir & inc_s.flag;
  assign borrow = en &  dir & dec_s.flag;

  // Value register: clear beats load beats counting.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= 8'h00;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= dir ? {dec_s.tens, dec_s.units} : {inc_s.tens, inc_s.units};
    end
  end

endmodule
`default_nettype wire

// File: rtl/min_sec_timer.sv
`default_nettype none
// ============================================================================
// Module      : min_sec_timer
// Description : Minutes:seconds BCD timebase with prescaler, up/down count,
//               preset load, per-update tick, up-count wrap pulse and a
//               sticky done flag for the down-count.
// Revision    : 1.0  initial release
// ============================================================================
module min_sec_timer
  import timer_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int MAX_MIN = 59
) (
  input  logic            clk,
  input  logic            rst,
  min_sec_timer_if.slave  bus
);

  localparam int               DIV      = CLK_HZ / TICK_HZ;
  localparam int               PRE_W    = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre;
  logic             done_r;
  logic             tick_r;
  logic             wrap_r;
  logic [7:0]       sec_q;
  logic [7:0]       min_q;
  logic [7:0]       ld_sec;
  logic [7:0]       ld_min;
  logic             halted;
  logic             en;
  logic             cnt_en;
  logic             ld;
  logic             time_zero;
  logic             zero_next;
  logic             sec_carry;
  logic             sec_borrow;
  logic             min_carry;
  logic             unused_min_borrow;

  // A finished down-count freezes everything until done is cleared or dir flips.
  assign halted    = done_r & bus.dir;
  assign en        = bus.run & ~halted & (pre == PRE_LAST);
  assign time_zero = (sec_q == 8'h00) && (min_q == 8'h00);
  assign zero_next = bus.dir && (min_q == 8'h00) && (sec_q == 8'h01);
  // Starting a down-count at 00:00 only raises done; never underflow to 59.
  assign cnt_en    = en & ~(bus.dir & time_zero);
  assign ld        = bus.load & ~bus.clear;
  assign ld_sec    = bcd2_clamp(bus.load_sec, SEC_MOD - 1);
  assign ld_min    = bcd2_clamp(bus.load_min, MAX_MIN);

  bcd2_mod_counter #(.MOD(SEC_MOD)) u_sec (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en),
    .dir      (bus.dir),
    .load     (ld),
    .load_val (ld_sec),
    .clr      (bus.clear),
    .q        (sec_q),
    .carry    (sec_carry),
    .borrow   (sec_borrow)
  );

  bcd2_mod_counter #(.MOD(MAX_MIN + 1)) u_min (
    .clk      (clk),
    .rst      (rst),
    .en       (sec_carry | sec_borrow),
    .dir      (bus.dir),
    .load     (ld),
    .load_val (ld_min),
    .clr      (bus.clear),
    .q        (min_q),
    .carry    (min_carry),
    .borrow   (unused_min_borrow)
  );

  // Prescaler: restarts on reset/clear/load, parks at 0 while halted, holds on pause.
  always_ff @(posedge clk) begin
    if (rst || bus.clear || bus.load || halted) begin
      pre <= '0;
    end else if (bus.run) begin
      pre <= (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
    end
  end

  // Status and pulse registers with rst > clear > load > count priority.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      done_r <= 1'b0;
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end else if (bus.load) begin
      done_r <= 1'b0;
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end else begin
      tick_r <= cnt_en;
      wrap_r <= min_carry;
      if (en && bus.dir && (time_zero || zero_next)) begin
        done_r <= 1'b1;
      end
    end
  end

  assign bus.min_bcd = min_q;
  assign bus.sec_bcd = sec_q;
  assign bus.tick    = tick_r;
  assign bus.wrap    = wrap_r;
  assign bus.done    = done_r;

endmodule
`default_nettype wire

// File: tb/tb_min_sec_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_min_sec_timer
// Description : Scoreboard bench for min_sec_timer (DIV=10, MAX_MIN=2).
// Revision    : 1.0  initial release
// ============================================================================
module tb_min_sec_timer;

  localparam int MAXM = 2;

  typedef struct {
    logic [7:0] mn;
    logic [7:0] sc;
    logic       wr;
    logic       dn;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_mod, s_mod;
  bit   d_mod;
  int   cyc;
  int   nt;

  min_sec_timer_if bus ();

  min_sec_timer #(.CLK_HZ(10), .TICK_HZ(1), .MAX_MIN(MAXM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic push_up();
    logic w;
    w = 1'b0;
    s_mod++;
    if (s_mod == 60) begin
      s_mod = 0;
      m_mod++;
      if (m_mod > MAXM) begin
        m_mod = 0;
        w = 1'b1;
      end
    end
    sb.push_back('{to_bcd(m_mod), to_bcd(s_mod), w, d_mod});
  endtask

  task automatic push_down();
    if (s_mod == 0) begin
      s_mod = 59;
      m_mod--;
    end else begin
      s_mod--;
    end
    if (m_mod == 0 && s_mod == 0) d_mod = 1'b1;
    sb.push_back('{to_bcd(m_mod), to_bcd(s_mod), 1'b0, d_mod});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int budget, output int c);
    c = 0;
    forever begin
      step();
      c++;
      if (bus.tick === 1'b1) return;
      if (c >= budget) begin
        check("tick_timeout", 32'd0, 32'd1);
        return;
      end
    end
  endtask

  task automatic do_load(input logic [7:0] mn, input logic [7:0] sc);
    bus.load_min = mn;
    bus.load_sec = sc;
    bus.load     = 1'b1;
    step();
    bus.load     = 1'b0;
  endtask

  // Every tick pops one expected update from the scoreboard.
  always @(negedge clk) begin
    if (bus.tick === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_tick", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_min",  bus.min_bcd, e.mn);
        check("sb_sec",  bus.sec_bcd, e.sc);
        check("sb_wrap", bus.wrap,    e.wr);
        check("sb_done", bus.done,    e.dn);
      end
    end else if (bus.wrap === 1'b1) begin
      check("wrap_without_tick", 32'd1, 32'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.run = 1'b0; bus.clear = 1'b0; bus.dir = 1'b0; bus.load = 1'b0;
    bus.load_min = 8'h00; bus.load_sec = 8'h00;
    repeat (3) step();
    check("rst_min",  bus.min_bcd, 8'h00);
    check("rst_sec",  bus.sec_bcd, 8'h00);
    check("rst_tick", bus.tick, 1'b0);
    check("rst_wrap", bus.wrap, 1'b0);
    check("rst_done", bus.done, 1'b0);
    rst = 1'b0;

    // 1: up-count from reset
    m_mod = 0; s_mod = 0; d_mod = 1'b0;
    bus.run = 1'b1;
    push_up();
    wait_tick(20, cyc);
    check("first_tick_latency", cyc, 10);
    repeat (59) begin
      push_up();
      wait_tick(20, cyc);
    end
    check("t1_min", bus.min_bcd, 8'h01);
    check("t1_sec", bus.sec_bcd, 8'h00);

    // 2: wrap at MAX_MIN:59
    do_load(8'h02, 8'h58);
    m_mod = 2; s_mod = 58;
    check("t2_load_sec", bus.sec_bcd, 8'h58);
    push_up();
    wait_tick(20, cyc);
    check("t2_latency", cyc, 10);
    push_up();
    wait_tick(20, cyc);
    check("t2_wrap_min", bus.min_bcd, 8'h00);
    step();
    check("t2_wrap_one_cycle", bus.wrap, 1'b0);
    push_up();
    wait_tick(20, cyc);
    check("t2_done_up", bus.done, 1'b0);

    // 3: down-count to 00:00 then halt
    bus.dir = 1'b1;
    do_load(8'h01, 8'h01);
    m_mod = 1; s_mod = 1; d_mod = 1'b0;
    repeat (61) begin
      push_down();
      wait_tick(20, cyc);
    end
    check("t3_done", bus.done, 1'b1);
    nt = 0;
    repeat (30) begin
      step();
      if (bus.tick === 1'b1) nt++;
    end
    check("t3_halt_ticks", nt, 0);
    check("t3_halt_min", bus.min_bcd, 8'h00);
    check("t3_halt_sec", bus.sec_bcd, 8'h00);

    // done stays set while counting resumes upward
    bus.dir = 1'b0;
    push_up();
    wait_tick(20, cyc);
    check("t3_resume_latency", cyc, 10);
    check("t3_done_sticky", bus.done, 1'b1);

    // 4: pause at prescaler phase 6
    do_load(8'h00, 8'h10);
    m_mod = 0; s_mod = 10; d_mod = 1'b0;
    check("t4_load_clears_done", bus.done, 1'b0);
    repeat (6) step();
    bus.run = 1'b0;
    nt = 0;
    repeat (25) begin
      step();
      if (bus.tick === 1'b1) nt++;
    end
    check("t4_pause_ticks", nt, 0);
    check("t4_pause_sec", bus.sec_bcd, 8'h10);
    bus.run = 1'b1;
    push_up();
    wait_tick(20, cyc);
    check("t4_resume_latency", cyc, 4);

    // 5: clamped load, then load on an enable edge
    do_load(8'h3A, 8'h7F);
    check("t5_clamp_min", bus.min_bcd, 8'h02);
    check("t5_clamp_sec", bus.sec_bcd, 8'h59);
    repeat (9) step();
    do_load(8'h01, 8'h30);
    m_mod = 1; s_mod = 30;
    check("t5_load_wins_tick", bus.tick, 1'b0);
    check("t5_load_wins_sec", bus.sec_bcd, 8'h30);
    push_up();
    wait_tick(20, cyc);
    check("t5_restart_latency", cyc, 10);

    // 6: clear on the enable edge at 00:01, then rst with load
    bus.dir = 1'b1;
    do_load(8'h00, 8'h03);
    m_mod = 0; s_mod = 3; d_mod = 1'b0;
    push_down();
    wait_tick(20, cyc);
    push_down();
    wait_tick(20, cyc);
    check("t6_at_0001", bus.sec_bcd, 8'h01);
    repeat (9) step();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    bus.run   = 1'b0;
    check("t6_clr_sec",  bus.sec_bcd, 8'h00);
    check("t6_clr_done", bus.done, 1'b0);
    check("t6_clr_tick", bus.tick, 1'b0);
    step();
    check("t6_no_late_tick", bus.tick, 1'b0);
    rst = 1'b1;
    bus.load_min = 8'h01; bus.load_sec = 8'h11; bus.load = 1'b1;
    step();
    rst = 1'b0;
    bus.load = 1'b0;
    check("t6_rst_load_min", bus.min_bcd, 8'h00);
    check("t6_rst_load_sec", bus.sec_bcd, 8'h00);
    check("t6_rst_load_done", bus.done, 1'b0);

    check("sb_empty", sb.size(), 0);
    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
